// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM states, parity modes,
// default sizing and the frame parity helper.
package uart_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned TIMEOUT_DEF = 8191;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_mode_t;

    // xr is the XOR-reduction of the data byte.
    function automatic logic frame_parity(input logic en, input parity_mode_t mode, input logic xr);
        if (!en) return 1'b0;
        return (mode == PAR_ODD) ? ~xr : xr;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester and transmitter handshake bundle; slave is the scheduler's view,
// master is the view of the surrounding requesters and UART transmitter.
interface uart_tx_sched_if
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ack;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_parity;
    logic                      tx_done;

    modport slave (
        input  req, req_data, tx_done,
        output req_ack, tx_start, tx_data, tx_parity
    );

    modport master (
        output req, req_data, tx_done,
        input  req_ack, tx_start, tx_data, tx_parity
    );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin pick: requests above the pointer win first, otherwise the
// lowest-index request wraps around.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       any_req
);
    localparam int unsigned GID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] masked;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            mask[i] = (i > 32'(ptr));
        end
        masked  = req & mask;
        any_req = |req;
        grant   = '0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            if (req[i-1]) grant = GID_W'(i - 1);
        end
        if (|masked) begin
            for (int unsigned i = NUM_REQ; i > 0; i--) begin
                if (masked[i-1]) grant = GID_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules bytes from several requesters onto one UART transmitter with
// round-robin arbitration, parity generation and a WAIT-state timeout.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    uart_tx_sched_if.slave             bus,
    input  logic                       parity_en,
    input  logic                       parity_odd,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err,
    output logic                       err_flag,
    input  logic                       err_clr
);
    localparam int unsigned GID_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [GID_W-1:0] win;
    logic             any_req;

    assign cnt_inc = cnt + 1'b1;

    // grant_id doubles as the round-robin pointer, so every grant advances it.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (bus.req),
        .ptr     (grant_id),
        .grant   (win),
        .any_req (any_req)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            grant_id      <= GID_W'(NUM_REQ - 1);
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            err_flag      <= 1'b0;
            bus.req_ack   <= '0;
            bus.tx_start  <= 1'b0;
            bus.tx_data   <= '0;
            bus.tx_parity <= 1'b0;
        end else begin
            bus.req_ack  <= '0;
            bus.tx_start <= 1'b0;
            timeout_err  <= 1'b0;
            if (err_clr) err_flag <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state            <= ST_LOAD;
                        grant_id         <= win;
                        busy             <= 1'b1;
                        bus.req_ack[win] <= 1'b1;
                        bus.tx_data      <= bus.req_data[win*DATA_W +: DATA_W];
                    end
                end
                ST_LOAD: begin
                    // Parity mode is sampled while in LOAD; the registered bit
                    // is valid alongside tx_start and held until the next LOAD.
                    state         <= ST_START;
                    bus.tx_start  <= 1'b1;
                    bus.tx_parity <= frame_parity(parity_en, parity_mode_t'(parity_odd),
                                                  ^bus.tx_data);
                end
                ST_START: begin
                    state <= ST_WAIT;
                    cnt   <= '0;
                end
                ST_WAIT: begin
                    if (bus.tx_done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CNT_END) begin
                            state       <= ST_IDLE;
                            busy        <= 1'b0;
                            timeout_err <= 1'b1;
                            err_flag    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a round-robin reference model predicts
// grant order, bytes and parity; a monitor compares each ack/start against it.
module tb_uart_tx_sched;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic parity_en = 1'b0;
    logic parity_odd = 1'b0;
    logic err_clr = 1'b0;
    logic [$clog2(NR)-1:0] grant_id;
    logic busy, timeout_err, err_flag;

    uart_tx_sched_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    uart_tx_sched #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .bus         (bus),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_flag    (err_flag),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: pending requests are served in round-robin order.
    typedef struct {
        int             id;
        logic [DW-1:0]  data;
        logic           par;
    } exp_t;

    exp_t exp_q[$];
    int   last_gnt = NR - 1;

    function automatic logic ref_parity(input logic [DW-1:0] d, input logic en, input logic odd);
        if (!en) return 1'b0;
        return ((($countones(d) % 2) == 1) ? 1'b1 : 1'b0) ^ odd;
    endfunction

    task automatic model_push(input logic [NR-1:0] mask, input logic [NR*DW-1:0] data,
                              input logic en, input logic odd);
        logic [NR-1:0] pending;
        pending = mask;
        while (pending != '0) begin
            for (int off = 1; off <= NR; off++) begin
                int   i;
                exp_t e;
                i = (last_gnt + off) % NR;
                if (pending[i]) begin
                    e.id   = i;
                    e.data = data[i*DW +: DW];
                    e.par  = ref_parity(e.data, en, odd);
                    exp_q.push_back(e);
                    pending[i] = 1'b0;
                    last_gnt   = i;
                    break;
                end
            end
        end
    endtask

    // Transmitter model: 1 = done after 1..4 WAIT cycles, 2 = done on the
    // timeout cycle, 0 = never done.
    int done_mode = 1;
    int idle_pulse_req = 0;

    initial begin
        int seen_req;
        seen_req = 0;
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (idle_pulse_req != seen_req) begin
                seen_req = idle_pulse_req;
                bus.tx_done = 1'b1;
                @(negedge clk);
                bus.tx_done = 1'b0;
            end else if (rst_n && bus.tx_start) begin
                if (done_mode == 1) begin
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                    bus.tx_done = 1'b1;
                    @(negedge clk);
                    bus.tx_done = 1'b0;
                end else if (done_mode == 2) begin
                    repeat (TO) @(negedge clk);
                    bus.tx_done = 1'b1;
                    @(negedge clk);
                    bus.tx_done = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every ack and checks the following start.
    exp_t cur;
    bit   have_cur = 1'b0;
    int   ack_cyc = 0;
    int   exp_ack_at = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            have_cur   = 1'b0;
            exp_ack_at = 0;
        end else begin
            if (bus.req_ack != '0) begin
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", 32'(bus.req_ack), 0);
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    ack_cyc  = cyc;
                    chk("ack_onehot", 32'(bus.req_ack), 32'(1) << cur.id);
                    chk("grant_id", 32'(grant_id), 32'(cur.id));
                    if (exp_ack_at != 0) begin
                        chk("b2b_gap", 32'(cyc), 32'(exp_ack_at));
                        exp_ack_at = 0;
                    end
                end
            end
            if (bus.tx_start) begin
                if (!have_cur) begin
                    chk("start_unexpected", 32'(bus.tx_start), 0);
                end else begin
                    chk("start_after_ack", 32'(cyc), 32'(ack_cyc + 1));
                    chk("tx_data", 32'(bus.tx_data), 32'(cur.data));
                    chk("tx_parity", 32'(bus.tx_parity), 32'(cur.par));
                    have_cur = 1'b0;
                end
            end
            if (bus.tx_done && busy && bus.req != '0) exp_ack_at = cyc + 2;
        end
    end

    // Requesters drop their request (and scramble their byte) once acked.
    task automatic tick();
        @(negedge clk);
        if (rst_n && bus.req_ack != '0) begin
            for (int i = 0; i < NR; i++) begin
                if (bus.req_ack[i]) begin
                    bus.req[i] = 1'b0;
                    bus.req_data[i*DW +: DW] = DW'($urandom);
                end
            end
        end
    endtask

    task automatic raise(input logic [NR-1:0] mask, input logic [NR*DW-1:0] data);
        model_push(mask, data, parity_en, parity_odd);
        bus.req_data = data;
        bus.req      = mask;
    endtask

    task automatic run_round(input logic [NR-1:0] mask, input logic [NR*DW-1:0] data,
                             input logic en, input logic odd, input bit lat);
        int n;
        parity_en  = en;
        parity_odd = odd;
        raise(mask, data);
        if (lat) begin
            tick();
            chk("ack_latency", 32'(bus.req_ack), 32'(mask));
            tick();
            chk("start_latency", 32'(bus.tx_start), 1);
        end
        n = 0;
        while (!(bus.req == '0 && !busy) && n < 300) begin
            tick();
            n++;
        end
        chk("round_done", {27'd0, busy, bus.req}, 0);
        tick();
        tick();
        chk("queue_drained", 32'(exp_q.size()), 0);
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!bus.tx_start && n < 20) begin
            tick();
            n++;
        end
        chk("start_seen", 32'(bus.tx_start), 1);
    endtask

    initial begin
        int k;
        int seen;
        logic ep;
        bus.req      = '0;
        bus.req_data = '0;
        repeat (3) tick();
        chk("rst_req_ack", 32'(bus.req_ack), 0);
        chk("rst_tx_start", 32'(bus.tx_start), 0);
        chk("rst_tx_data", 32'(bus.tx_data), 0);
        chk("rst_grant_id", 32'(grant_id), NR - 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err_flag", 32'(err_flag), 0);
        rst_n = 1'b1;
        tick();

        // Four simultaneous requesters twice: 0,1,2,3 then 0 first again.
        run_round(4'b1111, 32'h44332211, 1'b1, 1'b0, 1'b0);
        run_round(4'b1111, 32'h88776655, 1'b0, 1'b0, 1'b0);
        run_round(4'b0001, 32'h00000055, 1'b1, 1'b0, 1'b1);
        run_round(4'b0001, 32'h00000057, 1'b1, 1'b1, 1'b0);
        run_round(4'b0001, 32'h00000057, 1'b1, 1'b0, 1'b0);
        run_round(4'b0001, 32'h00000057, 1'b0, 1'b1, 1'b0);

        // tx_done while idle must not start anything.
        idle_pulse_req++;
        repeat (4) begin
            tick();
            chk("idle_done_busy", 32'(busy), 0);
            chk("idle_done_ack", 32'(bus.req_ack), 0);
        end

        // Timeout, with parity controls changed after LOAD.
        done_mode  = 0;
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        ep = ref_parity(8'h57, 1'b1, 1'b0);
        raise(4'b0010, 32'h00005700);
        wait_start();
        parity_en  = 1'b0;
        parity_odd = 1'b1;
        k = 0;
        while (!timeout_err && k < TO + 10) begin
            tick();
            k++;
            chk("parity_hold", 32'(bus.tx_parity), 32'(ep));
        end
        chk("timeout_cycles", 32'(k), TO + 1);
        chk("err_flag_set", 32'(err_flag), 1);
        chk("busy_after_timeout", 32'(busy), 0);
        tick();
        chk("timeout_pulse_width", 32'(timeout_err), 0);
        chk("err_flag_sticky", 32'(err_flag), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", 32'(err_flag), 0);

        // tx_done on the very timeout cycle counts as success.
        done_mode = 2;
        raise(4'b0100, 32'h003C0000);
        wait_start();
        seen = 0;
        repeat (TO + 6) begin
            tick();
            if (timeout_err) seen++;
        end
        chk("done_at_timeout_err", 32'(seen), 0);
        chk("done_at_timeout_flag", 32'(err_flag), 0);
        chk("done_at_timeout_busy", 32'(busy), 0);

        // err_clr held across a timeout: set wins.
        done_mode = 0;
        err_clr = 1'b1;
        raise(4'b0001, 32'h000000C3);
        wait_start();
        k = 0;
        while (!timeout_err && k < TO + 10) begin
            tick();
            k++;
        end
        chk("set_wins_pulse", 32'(timeout_err), 1);
        chk("set_wins_flag", 32'(err_flag), 1);
        err_clr = 1'b0;
        tick();
        chk("err_flag_held", 32'(err_flag), 1);

        // Reset in the middle of WAIT.
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        raise(4'b1000, 32'hA5000000);
        wait_start();
        repeat (3) tick();
        chk("pre_reset_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ack", 32'(bus.req_ack), 0);
        chk("mid_rst_tx_start", 32'(bus.tx_start), 0);
        chk("mid_rst_tx_data", 32'(bus.tx_data), 0);
        chk("mid_rst_tx_parity", 32'(bus.tx_parity), 0);
        chk("mid_rst_grant_id", 32'(grant_id), NR - 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_timeout_err", 32'(timeout_err), 0);
        chk("mid_rst_err_flag", 32'(err_flag), 0);
        last_gnt = NR - 1;
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        done_mode = 1;
        run_round(4'b0100, 32'h00990000, 1'b1, 1'b0, 1'b1);

        // Randomized traffic.
        repeat (25) begin
            run_round(NR'($urandom_range(1, (1 << NR) - 1)), $urandom,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected to end earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
